// File: rtl/mem_copy_engine_if.sv
// Bus bundle between the copy engine, its requester and the shared data-memory port.
interface mem_copy_engine_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 11
);
    // request side
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  length;
    logic              fill_en;
    logic [DATA_W-1:0] fill_value;
    logic              busy;
    logic              done;
    logic              err;

    // data-memory side
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    // engine view
    modport master (
        input  start, src_addr, dst_addr, length, fill_en, fill_value, mem_read_data,
        output busy, done, err, mem_read, mem_write, mem_address, mem_write_data
    );

    // requester / memory view
    modport slave (
        output start, src_addr, dst_addr, length, fill_en, fill_value, mem_read_data,
        input  busy, done, err, mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Block-transfer initiator: copies a run of words from src to dst, or fills dst with a
// constant, by driving the same data-memory port a CPU MEM stage uses.
// Moore machine: 2 cycles per copied word (read then write), 1 cycle per filled word.
// All outputs are flops loaded from the next-state decode, so each output reflects the
// state of the current cycle and clears asynchronously on reset.
module mem_copy_engine #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LEN_W     = 11,
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic clk,
    input  logic rst,
    mem_copy_engine_if.master bus
);

    localparam int unsigned EXT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state, state_nxt;

    logic [ADDR_W-1:0] src_ptr, src_ptr_nxt;
    logic [ADDR_W-1:0] dst_ptr, dst_ptr_nxt;
    logic [LEN_W-1:0]  remaining, remaining_nxt;
    logic [DATA_W-1:0] buffer, buffer_nxt;
    logic              fill_en_q, fill_en_nxt;
    logic [DATA_W-1:0] fill_value_q, fill_value_nxt;
    logic              range_err_q, range_err_nxt;

    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic              err_q, err_nxt;
    logic              mem_read_q, mem_read_nxt;
    logic              mem_write_q, mem_write_nxt;
    logic [ADDR_W-1:0] mem_address_q, mem_address_nxt;
    logic [DATA_W-1:0] mem_write_data_q, mem_write_data_nxt;

    logic [EXT_W-1:0]  src_end_c;
    logic [EXT_W-1:0]  dst_end_c;
    logic              range_err_c;

    // One-past-last address of each range, one bit wider so the sum cannot wrap
    assign src_end_c   = EXT_W'(bus.src_addr) + EXT_W'(bus.length);
    assign dst_end_c   = EXT_W'(bus.dst_addr) + EXT_W'(bus.length);
    assign range_err_c = (dst_end_c > EXT_W'(MEM_DEPTH)) ||
                         (!bus.fill_en && (src_end_c > EXT_W'(MEM_DEPTH)));

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            src_ptr          <= '0;
            dst_ptr          <= '0;
            remaining        <= '0;
            buffer           <= '0;
            fill_en_q        <= 1'b0;
            fill_value_q     <= '0;
            range_err_q      <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state            <= state_nxt;
            src_ptr          <= src_ptr_nxt;
            dst_ptr          <= dst_ptr_nxt;
            remaining        <= remaining_nxt;
            buffer           <= buffer_nxt;
            fill_en_q        <= fill_en_nxt;
            fill_value_q     <= fill_value_nxt;
            range_err_q      <= range_err_nxt;
            busy_q           <= busy_nxt;
            done_q           <= done_nxt;
            err_q            <= err_nxt;
            mem_read_q       <= mem_read_nxt;
            mem_write_q      <= mem_write_nxt;
            mem_address_q    <= mem_address_nxt;
            mem_write_data_q <= mem_write_data_nxt;
        end
    end

    // Next-state, datapath update and next-cycle output decode
    always_comb begin
        state_nxt          = state;
        src_ptr_nxt        = src_ptr;
        dst_ptr_nxt        = dst_ptr;
        remaining_nxt      = remaining;
        buffer_nxt         = buffer;
        fill_en_nxt        = fill_en_q;
        fill_value_nxt     = fill_value_q;
        range_err_nxt      = range_err_q;
        busy_nxt           = 1'b0;
        done_nxt           = 1'b0;
        err_nxt            = 1'b0;
        mem_read_nxt       = 1'b0;
        mem_write_nxt      = 1'b0;
        mem_address_nxt    = '0;
        mem_write_data_nxt = '0;

        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    src_ptr_nxt    = bus.src_addr;
                    dst_ptr_nxt    = bus.dst_addr;
                    remaining_nxt  = bus.length;
                    fill_en_nxt    = bus.fill_en;
                    fill_value_nxt = bus.fill_value;
                    range_err_nxt  = range_err_c;
                    if (range_err_c || (bus.length == '0)) begin
                        state_nxt = S_DONE;
                    end else if (bus.fill_en) begin
                        state_nxt = S_WRITE;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                buffer_nxt  = bus.mem_read_data;
                src_ptr_nxt = src_ptr + ADDR_W'(1);
                state_nxt   = S_WRITE;
            end
            S_WRITE: begin
                dst_ptr_nxt   = dst_ptr + ADDR_W'(1);
                remaining_nxt = remaining - LEN_W'(1);
                if (remaining == LEN_W'(1)) begin
                    state_nxt = S_DONE;
                end else if (fill_en_q) begin
                    state_nxt = S_WRITE;
                end else begin
                    state_nxt = S_READ;
                end
            end
            S_DONE: begin
                range_err_nxt = 1'b0;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Output values for the cycle the machine is about to enter
        unique case (state_nxt)
            S_READ: begin
                busy_nxt        = 1'b1;
                mem_read_nxt    = 1'b1;
                mem_address_nxt = src_ptr_nxt;
            end
            S_WRITE: begin
                busy_nxt           = 1'b1;
                mem_write_nxt      = 1'b1;
                mem_address_nxt    = dst_ptr_nxt;
                mem_write_data_nxt = fill_en_nxt ? fill_value_nxt : buffer_nxt;
            end
            S_DONE: begin
                done_nxt = 1'b1;
                err_nxt  = range_err_nxt;
            end
            default: begin
            end
        endcase
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: directed cases plus random transfers,
// compared against a word-array reference model of the data memory.
module tb_mem_copy_engine;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned LEN_W     = 11;
    localparam int unsigned MEM_DEPTH = 1024;

    logic clk;
    logic rst;

    mem_copy_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    mem_copy_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DATA_W-1:0] mem     [0:MEM_DEPTH-1];
    logic [DATA_W-1:0] ref_mem [0:MEM_DEPTH-1];

    int n_cmp;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge
    assign bus.mem_read_data = mem[bus.mem_address[9:0]];
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_address[9:0]] = bus.mem_write_data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < int'(MEM_DEPTH); i++) begin
            if (mem[i] !== ref_mem[i]) diffs++;
        end
        check(tag, 64'(diffs), 64'd0);
    endtask

    // Issue one request and follow it cycle by cycle; optionally pulse a second,
    // conflicting start in cycle 'inject' which the engine must ignore.
    task automatic run_xfer(input string name, input logic [31:0] src, input logic [31:0] dst,
                            input int len, input logic fill, input logic [31:0] val,
                            input int inject);
        longint unsigned   src_end, dst_end;
        logic              e_err;
        int                exp_done, exp_rd, exp_wr;
        int                rd_cnt, wr_cnt, done_cyc;
        logic [DATA_W-1:0] exp_w [$];
        logic [DATA_W-1:0] w;

        src_end  = longint'(src) + longint'(len);
        dst_end  = longint'(dst) + longint'(len);
        e_err    = (dst_end > MEM_DEPTH) || (!fill && (src_end > MEM_DEPTH));
        exp_done = (e_err || len == 0) ? 1 : (fill ? len + 1 : 2 * len + 1);
        exp_rd   = (e_err || len == 0 || fill) ? 0 : len;
        exp_wr   = (e_err || len == 0) ? 0 : len;
        exp_w.delete();
        if (!e_err) begin
            for (int i = 0; i < len; i++) begin
                w = fill ? val : ref_mem[src + 32'(i)];
                exp_w.push_back(w);
                ref_mem[dst + 32'(i)] = w;
            end
        end

        @(negedge clk);
        bus.src_addr   = src;
        bus.dst_addr   = dst;
        bus.length     = LEN_W'(len);
        bus.fill_en    = fill;
        bus.fill_value = val;
        bus.start      = 1'b1;
        @(posedge clk);

        rd_cnt   = 0;
        wr_cnt   = 0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 2 * len + 8; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check({name, ".excl"}, 64'(bus.mem_read & bus.mem_write), 64'd0);
            if (bus.mem_read) begin
                check({name, ".rd_addr"}, 64'(bus.mem_address), 64'(src + 32'(rd_cnt)));
                rd_cnt++;
            end
            if (bus.mem_write) begin
                check({name, ".wr_addr"}, 64'(bus.mem_address), 64'(dst + 32'(wr_cnt)));
                check({name, ".wr_in_range"}, 64'(wr_cnt < exp_w.size()), 64'd1);
                if (wr_cnt < exp_w.size())
                    check({name, ".wr_data"}, 64'(bus.mem_write_data), 64'(exp_w[wr_cnt]));
                wr_cnt++;
            end
            if (!bus.mem_read && !bus.mem_write)
                check({name, ".idle_bus"}, {bus.mem_address, bus.mem_write_data}, 64'd0);
            check({name, ".busy"}, 64'(bus.busy), 64'((cyc < exp_done) && (exp_done > 1)));
            if (bus.done) begin
                check({name, ".err"}, 64'(bus.err), 64'(e_err));
                done_cyc = cyc;
                break;
            end
            if (cyc == inject) begin
                bus.src_addr   = 32'd500;
                bus.dst_addr   = 32'd600;
                bus.length     = LEN_W'(7);
                bus.fill_en    = 1'b1;
                bus.fill_value = 32'h0BAD_F00D;
                bus.start      = 1'b1;
            end
        end
        bus.start = 1'b0;

        check({name, ".done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({name, ".n_reads"}, 64'(rd_cnt), 64'(exp_rd));
        check({name, ".n_writes"}, 64'(wr_cnt), 64'(exp_wr));
        @(negedge clk);
        check({name, ".done_1cyc"}, 64'({bus.done, bus.err, bus.busy}), 64'd0);
        check_mem({name, ".mem"});
    endtask

    initial begin
        logic [31:0] v, s, d;
        int          l, mode;

        n_cmp          = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.src_addr   = '0;
        bus.dst_addr   = '0;
        bus.length     = '0;
        bus.fill_en    = 1'b0;
        bus.fill_value = '0;
        for (int i = 0; i < int'(MEM_DEPTH); i++) begin
            v          = $urandom;
            mem[i]     = v;
            ref_mem[i] = v;
        end
        for (int i = 0; i < 4; i++) begin
            mem[i]     = 32'(i + 1);
            ref_mem[i] = 32'(i + 1);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.ctrl", 64'({bus.busy, bus.done, bus.err, bus.mem_read, bus.mem_write}), 64'd0);
        check("reset.bus", {bus.mem_address, bus.mem_write_data}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle.ctrl", 64'({bus.busy, bus.done, bus.mem_read, bus.mem_write}), 64'd0);

        // Directed cases
        run_xfer("copy4", 32'd0, 32'd100, 4, 1'b0, 32'd0, 0);
        check("copy4.data", {ref_mem[101], ref_mem[100]}, 64'h0000_0002_0000_0001);
        run_xfer("fill3", 32'd0, 32'd10, 3, 1'b1, 32'hDEAD_BEEF, 0);
        check("fill3.word", 64'(mem[12]), 64'hDEAD_BEEF);
        run_xfer("len0", 32'd5, 32'd6, 0, 1'b0, 32'd0, 0);
        run_xfer("range_src", 32'd1022, 32'd0, 4, 1'b0, 32'd0, 0);
        run_xfer("range_dst", 32'd0, 32'd1022, 3, 1'b1, 32'h1234_5678, 0);
        run_xfer("fill_edge", 32'd0, 32'd1021, 3, 1'b1, 32'hCAFE_0001, 0);
        run_xfer("copy_edge", 32'd1020, 32'd0, 4, 1'b0, 32'd0, 0);
        run_xfer("busy_start", 32'd20, 32'd40, 2, 1'b0, 32'd0, 2);
        run_xfer("overlap_up", 32'd300, 32'd302, 6, 1'b0, 32'd0, 0);
        run_xfer("overlap_dn", 32'd402, 32'd400, 6, 1'b0, 32'd0, 0);

        // Reset mid-copy, after the second write edge
        @(negedge clk);
        bus.src_addr = 32'd0;
        bus.dst_addr = 32'd200;
        bus.length   = LEN_W'(4);
        bus.fill_en  = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid.ctrl", 64'({bus.busy, bus.done, bus.err, bus.mem_read, bus.mem_write}), 64'd0);
        check("rst_mid.bus", {bus.mem_address, bus.mem_write_data}, 64'd0);
        ref_mem[200] = ref_mem[0];
        ref_mem[201] = ref_mem[1];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid.no_done", 64'(bus.done), 64'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid.after", 64'({bus.done, bus.busy}), 64'd0);
        end
        check_mem("rst_mid.mem");

        // Random transfers, biased toward boundaries and overlaps
        for (int t = 0; t < 30; t++) begin
            mode = int'($urandom_range(0, 3));
            l    = int'($urandom_range(0, 20));
            s    = $urandom_range(0, MEM_DEPTH - 1);
            d    = $urandom_range(0, MEM_DEPTH - 1);
            if (mode == 1) d = s + $urandom_range(0, 4);
            if (mode == 2) s = MEM_DEPTH - $urandom_range(1, 24);
            if (mode == 3) d = MEM_DEPTH - $urandom_range(1, 24);
            run_xfer("rand", s, d, l, 1'($urandom_range(0, 1)), $urandom, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
